// File: rtl/posit_conv_arbiter.sv
// Round-robin share of one posit_conv among NREQ clients, tag + result FIFOs.
// Optional counters stat_issued/stat_stall under POSIT_CONV_ARB_STATS_EN.
module posit_conv_arbiter_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
endmodule

module posit_conv_arbiter #(
  parameter  int N     = 36,
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      conv_in,
  output logic              conv_start,
  input  logic [63:0]       conv_out,
  input  logic              conv_done,
  output logic              res_valid,
  output logic [63:0]       res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
`ifdef POSIT_CONV_ARB_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    data;
  } res_t;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] idx;
  logic           hit;
  logic [CW-1:0]  cnt;
  logic           any_req;
  logic           room;
  logic           issue;
  logic           pop;

  logic [IDW-1:0] tag_head;
  logic           tag_empty;
  logic           tag_pop;

  res_t           res_in;
  res_t           res_head;
  logic           res_empty;

  assign any_req = |req_valid;
  assign room    = (cnt < CW'(DEPTH));
  assign issue   = any_req && room;
  assign pop     = res_valid && res_ready;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_start <= 1'b0;
      conv_in    <= '0;
      ptr        <= '0;
    end else begin
      conv_start <= issue;
      if (issue) begin
        conv_in <= req_data[int'(gnt)*N +: N];
        ptr     <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case ({issue, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign busy = (cnt != '0);

  posit_conv_arbiter_fifo #(
    .W     (IDW),
    .DEPTH (DEPTH)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .din   (gnt),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty)
  );

  assign tag_pop      = conv_done && !tag_empty;
  assign res_in.id    = tag_head;
  assign res_in.data  = conv_out;

  // credit limit guarantees the result FIFO never overflows
  posit_conv_arbiter_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_res (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_pop),
    .din   (res_in),
    .pop   (pop),
    .dout  (res_head),
    .empty (res_empty)
  );

  assign res_valid = !res_empty;
  assign res_data  = res_head.data;
  assign res_id    = res_head.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (conv_done && tag_empty) begin
      err <= 1'b1;
    end
  end

`ifdef POSIT_CONV_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue) stat_issued <= stat_issued + 1'b1;
      if (any_req && !room) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_posit_conv_arbiter.sv
// Bench for posit_conv_arbiter: converter model, RR/credit reference model.
// Stat ports are checked when POSIT_CONV_ARB_STATS_EN is defined.
module tb_posit_conv_arbiter;
  localparam int N     = 36;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;
  localparam int L     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      conv_in;
  logic              conv_start;
  logic [63:0]       conv_out;
  logic              conv_done;
  logic              res_valid;
  logic [63:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              err;
`ifdef POSIT_CONV_ARB_STATS_EN
  logic [31:0]       stat_issued;
  logic [31:0]       stat_stall;
`endif

  int tests = 0;
  int fails = 0;

  posit_conv_arbiter #(
    .N     (N),
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .conv_in    (conv_in),
    .conv_start (conv_start),
    .conv_out   (conv_out),
    .conv_done  (conv_done),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
`ifdef POSIT_CONV_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // posit<36,2> to IEEE double; every posit36 value fits exactly
  function automatic logic [63:0] posit2dbl(input logic [35:0] p);
    logic [35:0] a;
    logic [34:0] t;
    logic        s;
    logic        r0;
    int          m;
    int          k;
    int          ex;
    if (p == 36'h0) return 64'h0;
    if (p == 36'h800000000) return 64'h7FF8000000000000;
    s  = p[35];
    a  = s ? (~p + 36'h1) : p;
    t  = a[34:0];
    r0 = t[34];
    m  = 0;
    for (int i = 34; i >= 0; i--) begin
      if (t[i] == r0) m++;
      else break;
    end
    k = r0 ? m - 1 : -m;
    if (m + 1 >= 35) t = '0;
    else t = t << (m + 1);
    ex = k * 4 + int'(t[34:33]) + 1023;
    return {s, ex[10:0], t[32:0], 19'h0};
  endfunction

  // converter: fixed L-stage pipeline
  logic [L-1:0] cv;
  logic [N-1:0] cd [L];
  logic         inj = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv <= '0;
      for (int i = 0; i < L; i++) cd[i] <= '0;
    end else begin
      cv    <= {cv[L-2:0], conv_start};
      cd[0] <= conv_in;
      for (int i = 1; i < L; i++) cd[i] <= cd[i-1];
    end
  end

  assign conv_done = cv[L-1] | inj;
  assign conv_out  = posit2dbl(cd[L-1]);

  // reference model
  bit          mon_en = 1'b0;
  int          mptr = 0;
  int          mcnt = 0;
  bit          exp_start = 1'b0;
  logic [N-1:0] exp_in = '0;
  int          q_id [$];
  logic [63:0] q_data [$];

  function automatic void clear_model();
    q_id.delete();
    q_data.delete();
    mptr      = 0;
    mcnt      = 0;
    exp_start = 1'b0;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] erdy;
    int  g;
    int  j;
    bit  iss;
    bit  popd;
    if (mon_en && rst_n) begin
      erdy = '0;
      g    = 0;
      iss  = 1'b0;
      popd = 1'b0;
      if (|req_valid && mcnt < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (req_valid[j]) begin
            g   = j;
            iss = 1'b1;
            break;
          end
        end
      end
      if (iss) erdy[g] = 1'b1;
      tests++;
      if (req_ready !== erdy) begin
        fails++;
        $display("FAIL mon_req_ready t=%0t got %b exp %b", $time, req_ready, erdy);
      end
      tests++;
      if (busy !== (mcnt != 0)) begin
        fails++;
        $display("FAIL mon_busy t=%0t got %b exp %0d", $time, busy, mcnt != 0);
      end
      tests++;
      if (conv_start !== exp_start) begin
        fails++;
        $display("FAIL mon_conv_start t=%0t got %b exp %b", $time, conv_start, exp_start);
      end
      if (exp_start) begin
        tests++;
        if (conv_in !== exp_in) begin
          fails++;
          $display("FAIL mon_conv_in t=%0t got %h exp %h", $time, conv_in, exp_in);
        end
      end
      if (res_valid === 1'b1 && q_id.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_spurious_res t=%0t res_valid=1 exp none outstanding", $time);
      end else if (res_valid === 1'b1 && res_ready) begin
        tests++;
        if (res_id !== IDW'(q_id[0]) || res_data !== q_data[0]) begin
          fails++;
          $display("FAIL mon_result t=%0t got id=%0d data=%h exp id=%0d data=%h",
                   $time, res_id, res_data, q_id[0], q_data[0]);
        end
        void'(q_id.pop_front());
        void'(q_data.pop_front());
        popd = 1'b1;
      end
      exp_start = iss;
      if (iss) begin
        exp_in = req_data[g*N +: N];
        q_id.push_back(g);
        q_data.push_back(posit2dbl(req_data[g*N +: N]));
        mptr = (g + 1) % NREQ;
      end
      mcnt = mcnt + int'(iss) - int'(popd);
    end
  end

  task automatic do_reset();
    mon_en    = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    inj       = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_idle();
    bool_wait: begin
      req_valid = '0;
      res_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (!busy && !res_valid) disable bool_wait;
      end
      tests++;
      fails++;
      $display("FAIL drain_timeout busy=%b res_valid=%b exp idle", busy, res_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = {$urandom, $urandom} & 36'hFFFFFFFFF;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({conv_start, res_valid, busy, err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 0000", {conv_start, res_valid, busy, err});
    end
    tests++;
    if (conv_in !== '0 || req_ready !== '0) begin
      fails++;
      $display("FAIL reset_conv_in got %h/%b exp 0/0", conv_in, req_ready);
    end
    @(posedge clk);
    #1;
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int hit;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    req_data[2*N +: N] = 36'h400000000;
    req_valid = 4'b0100;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready got %b exp 0100", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    hit = 0;
    for (int c = 1; c <= 20 && hit == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (conv_start !== 1'b1) begin
          fails++;
          $display("FAIL single_start got %b exp 1", conv_start);
        end
      end
      if (res_valid) hit = c;
    end
    tests++;
    if (hit != 2 + L) begin
      fails++;
      $display("FAIL single_latency got %0d exp %0d", hit, 2 + L);
    end
    tests++;
    if (res_data !== 64'h3FF0000000000000 || res_id !== 2'd2) begin
      fails++;
      $display("FAIL single_result got %h id %0d exp 3ff0000000000000 id 2", res_data, res_id);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_fall got busy=%b rv=%b exp 0 0", busy, res_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] e;
    do_reset();
    res_ready = 1'b1;
    rand_data();
    req_valid = '1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      e = 4'b0001 << (j % NREQ);
      tests++;
      if (req_ready !== e) begin
        fails++;
        $display("FAIL rr_grant cycle %0d got %b exp %b", j, req_ready, e);
      end
      @(posedge clk);
      #1;
      rand_data();
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int acc;
    int pops;
    do_reset();
    res_ready = 1'b0;
    rand_data();
    req_valid = 4'b0010;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[1]) acc++;
      @(posedge clk);
      #1;
      rand_data();
    end
    @(negedge clk);
    tests++;
    if (acc != DEPTH || req_ready !== '0) begin
      fails++;
      $display("FAIL bp_accepted got %0d rdy %b exp %0d rdy 0000", acc, req_ready, DEPTH);
    end
`ifdef POSIT_CONV_ARB_STATS_EN
    tests++;
    if (stat_issued !== 32'd8) begin
      fails++;
      $display("FAIL bp_stat_issued got %0d exp 8", stat_issued);
    end
`endif
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 100 && pops < 12; c++) begin
      @(negedge clk);
      if (req_ready[1]) acc++;
      if (res_valid && res_ready) pops++;
      @(posedge clk);
      #1;
      if (acc >= 12) req_valid = '0;
      else rand_data();
    end
    tests++;
    if (acc != 12 || pops != 12) begin
      fails++;
      $display("FAIL bp_totals got acc=%0d pops=%0d exp 12 12", acc, pops);
    end
    wait_idle();
  endtask

  task automatic test_simultaneous();
    int acc;
    do_reset();
    res_ready = 1'b0;
    rand_data();
    req_valid = 4'b0001;
    acc = 0;
    for (int c = 0; c < 30 && acc < DEPTH; c++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      @(posedge clk);
      #1;
    end
    repeat (L + 4) @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL simul_pop_cycle got rv=%b rdy=%b exp 1 0000", res_valid, req_ready);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL simul_next_issue got %b exp 0001", req_ready);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL simul_full_again got rdy=%b busy=%b exp 0000 1", req_ready, busy);
    end
    wait_idle();
  endtask

  task automatic test_error();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pre got %b exp 0", err);
    end
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_set got err=%b rv=%b exp 1 0", err, res_valid);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky got %b exp 1", err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b1;
    rand_data();
    req_valid = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    tests++;
    if ({conv_start, res_valid, busy, err} !== 4'b0 || conv_in !== '0 || req_ready !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got %b %h %b exp 0000 0 0000",
               {conv_start, res_valid, busy, err}, conv_in, req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL midrst_stale cycle %0d got rv=%b err=%b exp 0 0", c, res_valid, err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/posit_conv_arbiter.md
Name: posit_conv_arbiter

Overview:
- Shares one posit_conv converter (N-bit posit in, 64-bit IEEE double out, start/done handshake) among NREQ requesters.
- Arbitrates requests round-robin, one issue per cycle.
- Tags each issued operation with its requester ID in an in-order tag FIFO.
- Buffers completed results in a result FIFO with valid/ready backpressure.
- Sits between the requester clients and the single posit_conv instance in the posit datapath.

Parameters:
- N, 36, posit width of requests and of conv_in.
- NREQ, 4, number of requesters (2..16).
- DEPTH, 8, result FIFO depth, equal to the max outstanding operations (power of 2).
- Local: IDW = ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*N  per-requester posit; requester i occupies bits [i*N +: N].
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle.
- conv_in  out  N  posit operand to the converter.
- conv_start  out  1  converter start strobe.
- conv_out  in  64  converter result.
- conv_done  in  1  converter result valid.
- res_valid  out  1  result available.
- res_data  out  64  converted double.
- res_id  out  IDW  requester index that owns res_data.
- res_ready  in  1  result consumer accept.
- busy  out  1  operations outstanding.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0):
  - conv_start=0, conv_in=0, res_valid=0, busy=0, err=0.
  - RR pointer=0, credit count=0, both FIFOs empty.
  - Reset mid-operation discards all in-flight state.
- Credit count cnt (0..DEPTH) = ops issued but not yet popped from the result FIFO.
  - +1 on issue; -1 on res_valid&res_ready; both in one cycle: unchanged.
  - busy = (cnt!=0).
- Arbitration: the grant g is the first index i at or after ptr, wrapping, with req_valid[i]=1.
- Issue condition: any req_valid AND cnt<DEPTH.
- On issue in cycle t:
  - req_ready[g]=1 combinationally in cycle t; all other req_ready bits are 0.
  - Registered at t+1: conv_start=1, conv_in=req_data[g].
  - Tag FIFO push g; ptr <= (g+1) mod NREQ.
- No issue: conv_start=0 next cycle, conv_in holds its last value, ptr holds.
- cnt==DEPTH: req_ready=0 for all requesters; requests wait, with no starvation beyond NREQ-1 grants.
- conv_done=1 with tag FIFO non-empty: push {tag head, conv_out} into the result FIFO and pop the tag in the same edge.
  - Results are assumed in-order, as posit_conv is a fixed pipeline.
- conv_done=1 with tag FIFO empty: result dropped, err<=1 (sticky until reset).
- The result FIFO cannot overflow because of the credit limit.
- The result FIFO is show-ahead: res_valid=!empty, and res_data/res_id come from the head.
  - Pop on res_valid&res_ready.
  - A push and a pop in the same cycle are both honoured.
- Latency: converter latency L (done L cycles after start); accept at t gives res_valid at t+2+L when the FIFO is empty.
- Throughput: one issue per cycle sustained while res_ready=1.

Optional Feature:
- Macro POSIT_CONV_ARB_STATS_EN.
- When defined, adds output ports stat_issued[31:0] and stat_stall[31:0], both reset to 0 and wrapping at 2^32.
  - stat_issued counts issues.
  - stat_stall counts cycles with any req_valid but cnt==DEPTH.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single request: after reset, requester 2 presents 0x400000000 (posit 1.0). Required: req_ready=0100 same cycle; conv_start at t+1; res_data=0x3FF0000000000000, res_id=2, at t+2+L; busy falls after the pop.
- Round-robin: all 4 requesters valid continuously with res_ready=1. Required: grant order 0,1,2,3,0,1…; res_id sequence matches the grant order.
- Backpressure: res_ready=0, 12 requests from requester 1. Required: exactly 8 accepted; req_ready=0 thereafter; stat_issued=8. After res_ready=1, the remaining 4 are accepted and 12 results are returned in order.
- Simultaneous: cnt==DEPTH with a pop and a pending request in the same cycle. Required: no issue that cycle (cnt<DEPTH false), issue the next cycle, cnt stays 8.
- Error: conv_done pulsed with no outstanding ops. Required: err=1 and held; no res_valid.
- Reset mid-stream: rst_n low while 3 ops are in flight. Required: all outputs 0 immediately; no stale results after reset release.
